scan_uart_bridge: RTL and testbench

Host-side front end for the scan chain: a UART command bridge that sits directly upstream of the scan controller. It receives byte commands over an 8N1 serial line and drives the controller's design-select and input bus. It waits for a completed scan (rising edge of ready), captures the controller's output bus and returns it over serial. This lets a bench PC select and exercise any design on the chain without extra pins.

---
 rtl/scan_uart_bridge.sv | 256 +++++++++++++++++++++++++
 tb/tb_scan_uart_bridge.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_uart_bridge.sv
// scan_uart_bridge
//   UART (8N1) command bridge in front of the scan controller. A host sends
//   byte commands to pick a design on the chain, drive its inputs, and read
//   its outputs back after a completed scan.
//     'S' a1 a2 : active_select <= {a1[0], a2}, reply 'K'
//     'W' a1    : inputs <= a1, reply 'K'
//     'R'       : wait for a fresh ready rising edge, reply captured outputs
//                 (reply 'E' if none arrives within TIMEOUT cycles)
//     other     : reply '?'
// Ports
//   clk           system clock, shared with the scan controller
//   reset         asynchronous active-high reset
//   uart_rx       serial in, idle high, asynchronous to clk
//   uart_tx       serial out, idle high
//   active_select design index to the controller
//   inputs        value driven into the selected design
//   outputs       selected design's outputs from the controller
//   ready         controller scan-complete flag
module scan_uart_bridge #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TIMEOUT      = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic       uart_tx,
    output logic [8:0] active_select,
    output logic [7:0] inputs,
    input  logic [7:0] outputs,
    input  logic       ready
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, ARG1, ARG2, WAIT_RDY, REPLY, REPLY_WAIT} state_t;

    // ---------------- receiver ----------------
    logic            rx_s1_q, rx_s2_q, rx_s3_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_valid;
    logic            rx_fall;

    // rx_s3_q only exists to find the falling edge, so a line left low after
    // a framing error cannot start a new byte until it has gone high again.
    assign rx_fall = rx_s3_q & ~rx_s2_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    // still high at mid start bit: a glitch, not a start
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_state_d = RX_IDLE;
                    rx_valid   = rx_s2_q;  // stop=0 drops the byte
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // ---------------- transmitter ----------------
    logic            tx_q, tx_busy_q, tx_start;
    logic [8:0]      tx_shift_q;
    logic [CW-1:0]   tx_cnt_q;
    logic [3:0]      tx_bit_q;
    logic [7:0]      reply_q, reply_d;

    // Bit 0 is the start bit, 1..8 data, 9 stop; each bit holds CLKS_PER_BIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_shift_q <= '1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
        end else if (tx_start) begin
            tx_q       <= 1'b0;
            tx_busy_q  <= 1'b1;
            tx_shift_q <= {1'b1, reply_q};
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
        end else if (tx_busy_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_q   <= '0;
                tx_bit_q   <= tx_bit_q + 4'd1;
                tx_q       <= tx_shift_q[0];
                tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_q      <= 1'b1;
                end
            end else begin
                tx_cnt_q <= tx_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- command FSM ----------------
    state_t          state_q, state_d;
    logic            is_sel_q, is_sel_d;
    logic            sel_hi_q, sel_hi_d;
    logic [8:0]      sel_q, sel_d;
    logic [7:0]      inputs_q, inputs_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            rdy_prev_q;
    logic            rdy_edge, tmo_hit;

    assign rdy_edge = ready & ~rdy_prev_q;
    assign tmo_hit  = (tmo_q == TMO_LAST);

    always_comb begin
        state_d  = state_q;
        is_sel_d = is_sel_q;
        sel_hi_d = sel_hi_q;
        sel_d    = sel_q;
        inputs_d = inputs_q;
        reply_d  = reply_q;
        tx_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_shift_q)
                        8'h53:   begin is_sel_d = 1'b1; state_d = ARG1; end
                        8'h57:   begin is_sel_d = 1'b0; state_d = ARG1; end
                        8'h52:   state_d = WAIT_RDY;
                        default: begin reply_d = 8'h3F; state_d = REPLY; end
                    endcase
                end
            end
            ARG1: begin
                if (rx_valid) begin
                    if (is_sel_q) begin
                        sel_hi_d = rx_shift_q[0];
                        state_d  = ARG2;
                    end else begin
                        inputs_d = rx_shift_q;
                        reply_d  = 8'h4B;
                        state_d  = REPLY;
                    end
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            ARG2: begin
                if (rx_valid) begin
                    sel_d   = {sel_hi_q, rx_shift_q};
                    reply_d = 8'h4B;
                    state_d = REPLY;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                end
            end
            WAIT_RDY: begin
                // edge checked first so it wins over a coincident timeout
                if (rdy_edge) begin
                    reply_d = outputs;
                    state_d = REPLY;
                end else if (tmo_hit) begin
                    reply_d = 8'h45;
                    state_d = REPLY;
                end
            end
            REPLY: begin
                tx_start = 1'b1;
                state_d  = REPLY_WAIT;
            end
            REPLY_WAIT: begin
                if (!tx_busy_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if ((state_d != state_q) || rx_valid) tmo_d = '0;
        else if (tmo_q != TMO_MAX)            tmo_d = tmo_q + 1'b1;
        else                                  tmo_d = tmo_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            is_sel_q   <= 1'b0;
            sel_hi_q   <= 1'b0;
            sel_q      <= '0;
            inputs_q   <= '0;
            reply_q    <= '0;
            tmo_q      <= '0;
            rdy_prev_q <= 1'b1;  // a ready already high out of reset is not an edge
        end else begin
            state_q    <= state_d;
            is_sel_q   <= is_sel_d;
            sel_hi_q   <= sel_hi_d;
            sel_q      <= sel_d;
            inputs_q   <= inputs_d;
            reply_q    <= reply_d;
            tmo_q      <= tmo_d;
            rdy_prev_q <= ready;
        end
    end

    assign uart_tx       = tx_q;
    assign active_select = sel_q;
    assign inputs        = inputs_q;

endmodule

// File: tb/tb_scan_uart_bridge.sv
module tb_scan_uart_bridge;

    localparam int CPB = 4;
    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] outputs = 8'h00;
    logic       uart_tx;
    logic [8:0] active_select;
    logic [7:0] inputs;

    int checks = 0;
    int errors = 0;
    int tx_falls = 0;
    logic [8:0] rxq[$];

    scan_uart_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .active_select(active_select), .inputs(inputs),
        .outputs(outputs), .ready(ready)
    );

    always #5 clk = ~clk;

    always @(negedge uart_tx) if (!reset) tx_falls++;

    // Serial receiver for the DUT's replies; queue entries are {stop, data}.
    logic [8:0] mon_b;
    bit         mon_bad;
    initial begin
        forever begin
            @(negedge uart_tx);
            mon_bad = reset;
            repeat (CPB / 2) @(posedge clk);
            @(negedge clk);
            if (uart_tx !== 1'b0 || reset) mon_bad = 1'b1;
            for (int i = 0; i < 9; i++) begin
                repeat (CPB) @(negedge clk);
                mon_b[i] = uart_tx;
                if (reset) mon_bad = 1'b1;
            end
            if (!mon_bad) rxq.push_back(mon_b);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic get_reply(output logic [8:0] b, output bit got);
        got = 1'b0;
        b   = 9'h000;
        for (int i = 0; i < 400; i++) begin
            if (rxq.size() > 0) break;
            @(negedge clk);
        end
        if (rxq.size() > 0) begin
            got = 1'b1;
            b   = rxq.pop_front();
        end
    endtask

    task automatic wait_tx_fall(output bit got);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (uart_tx === 1'b0) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit bad_tx, bad_sel, bad_in;
        bad_tx = 0; bad_sel = 0; bad_in = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) bad_tx = 1;
            if (active_select !== 9'h000) bad_sel = 1;
            if (inputs !== 8'h00) bad_in = 1;
        end
        checks++; if (bad_tx)  begin errors++; $display("FAIL reset_uart_tx: saw a non-1 value, required 1 for 100 cycles"); end
        checks++; if (bad_sel) begin errors++; $display("FAIL reset_active_select: saw a nonzero value, required 000"); end
        checks++; if (bad_in)  begin errors++; $display("FAIL reset_inputs: saw a nonzero value, required 00"); end
        checks++;
        if (tx_falls !== 0 || rxq.size() !== 0) begin
            errors++; $display("FAIL reset_tx_idle: falls=%0d bytes=%0d, required 0 0", tx_falls, rxq.size());
        end
    endtask

    task automatic test_select();
        logic [8:0] b; bit got;
        send_byte(8'h53, 1'b1);
        send_byte(8'h01, 1'b1);
        checks++;
        if (active_select !== 9'h000) begin
            errors++; $display("FAIL sel_before_last_arg: got %h required 000", active_select);
        end
        send_byte(8'h2A, 1'b1);
        wait_tx_fall(got);
        checks++;
        if (!got || active_select !== 9'h12A) begin
            errors++; $display("FAIL sel_update: got %h (tx_start=%0d) required 12a", active_select, got);
        end
        get_reply(b, got);
        checks++;
        if (!got || b !== {1'b1, 8'h4B}) begin
            errors++; $display("FAIL sel_reply: got %h (seen=%0d) required 14b", b, got);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_write();
        logic [8:0] b; bit got;
        send_byte(8'h57, 1'b1);
        send_byte(8'hA5, 1'b1);
        get_reply(b, got);
        checks++;
        if (!got || b !== {1'b1, 8'h4B}) begin
            errors++; $display("FAIL write_reply: got %h (seen=%0d) required 14b", b, got);
        end
        checks++;
        if (inputs !== 8'hA5) begin
            errors++; $display("FAIL write_inputs: got %h required a5", inputs);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_read_edge();
        logic [8:0] b; bit got; int f0;
        ready   = 1'b1;
        outputs = 8'h3C;
        repeat (5) @(negedge clk);
        send_byte(8'h52, 1'b1);
        f0 = tx_falls;
        repeat (20) @(negedge clk);
        checks++;
        if (tx_falls !== f0 || rxq.size() !== 0) begin
            errors++; $display("FAIL read_no_early_reply: falls %0d->%0d bytes=%0d, required no activity", f0, tx_falls, rxq.size());
        end
        ready = 1'b0;
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        outputs = 8'hFF;
        get_reply(b, got);
        checks++;
        if (!got || b !== {1'b1, 8'h3C}) begin
            errors++; $display("FAIL read_reply: got %h (seen=%0d) required 13c", b, got);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [8:0] b; bit got; int f0;
        ready   = 1'b0;
        outputs = 8'h77;
        repeat (3) @(negedge clk);
        send_byte(8'h52, 1'b1);
        f0 = tx_falls;
        repeat (30) @(negedge clk);
        checks++;
        if (tx_falls !== f0 || rxq.size() !== 0) begin
            errors++; $display("FAIL timeout_not_early: falls %0d->%0d, required no activity", f0, tx_falls);
        end
        get_reply(b, got);
        checks++;
        if (!got || b !== {1'b1, 8'h45}) begin
            errors++; $display("FAIL timeout_reply: got %h (seen=%0d) required 145", b, got);
        end
        repeat (5) @(negedge clk);
        f0 = tx_falls;
        send_byte(8'h53, 1'b1);
        repeat (100) @(negedge clk);
        checks++;
        if (tx_falls !== f0 || rxq.size() !== 0) begin
            errors++; $display("FAIL arg_timeout_silent: falls %0d->%0d bytes=%0d, required no activity", f0, tx_falls, rxq.size());
        end
        checks++;
        if (active_select !== 9'h12A) begin
            errors++; $display("FAIL arg_timeout_sel: got %h required 12a", active_select);
        end
        send_byte(8'h00, 1'b1);
        get_reply(b, got);
        checks++;
        if (!got || b !== {1'b1, 8'h3F}) begin
            errors++; $display("FAIL unknown_reply_after_timeout: got %h (seen=%0d) required 13f", b, got);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_errors();
        logic [8:0] b; bit got; int f0;
        f0 = tx_falls;
        send_byte(8'h57, 1'b0);
        repeat (60) @(negedge clk);
        checks++;
        if (tx_falls !== f0 || rxq.size() !== 0) begin
            errors++; $display("FAIL framing_no_reply: falls %0d->%0d, required no activity", f0, tx_falls);
        end
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (tx_falls !== f0 || rxq.size() !== 0) begin
            errors++; $display("FAIL glitch_ignored: falls %0d->%0d, required no activity", f0, tx_falls);
        end
        send_byte(8'h00, 1'b1);
        get_reply(b, got);
        checks++;
        if (!got || b !== {1'b1, 8'h3F}) begin
            errors++; $display("FAIL after_errors_reply: got %h (seen=%0d) required 13f", b, got);
        end
        checks++;
        if (inputs !== 8'hA5) begin
            errors++; $display("FAIL after_errors_inputs: got %h required a5", inputs);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [8:0] b; bit got; int f0;
        send_byte(8'h53, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h05, 1'b1);
        wait_tx_fall(got);
        repeat (22) @(posedge clk);
        #2;
        checks++;
        if (!got || uart_tx !== 1'b0 || active_select !== 9'h005) begin
            errors++; $display("FAIL mid_reply_state: tx=%b sel=%h seen=%0d, required tx=0 sel=005", uart_tx, active_select, got);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (uart_tx !== 1'b1 || active_select !== 9'h000 || inputs !== 8'h00) begin
            errors++; $display("FAIL reset_mid_reply: tx=%b sel=%h in=%h, required 1 000 00", uart_tx, active_select, inputs);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        rxq.delete();
        send_byte(8'h53, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        f0 = tx_falls;
        repeat (80) @(negedge clk);
        checks++;
        if (tx_falls !== f0 || rxq.size() !== 0) begin
            errors++; $display("FAIL reset_in_arg2_silent: falls %0d->%0d, required no activity", f0, tx_falls);
        end
        send_byte(8'h57, 1'b1);
        send_byte(8'h11, 1'b1);
        get_reply(b, got);
        checks++;
        if (!got || b !== {1'b1, 8'h4B}) begin
            errors++; $display("FAIL post_reset_write_reply: got %h (seen=%0d) required 14b", b, got);
        end
        checks++;
        if (inputs !== 8'h11 || active_select !== 9'h000) begin
            errors++; $display("FAIL post_reset_write_regs: in=%h sel=%h, required 11 000", inputs, active_select);
        end
    endtask

    initial begin
        test_reset();
        test_select();
        test_write();
        test_read_edge();
        test_timeout();
        test_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
